// File: rtl/register_hash_32_if.sv
// Purpose: data/Q bundle for one SHA-256 hash-word accumulator.
// Latency: n/a (signal bundle only).
// Backpressure: none; data is consumed on every rising clk edge.
//
// Signals:
//   data : 32-bit word added to the stored hash word on each rising edge
//   Q    : current stored hash word, driven straight from the register
//
// Modports:
//   master : the compression-stage side; drives data, observes Q
//   slave  : the accumulator; consumes data, drives Q
interface register_hash_32_if;
    logic [31:0] data;
    logic [31:0] Q;

    modport master (output data, input  Q);
    modport slave  (input  data, output Q);
endinterface

// File: rtl/register_hash_32.sv
// Purpose: 32-bit accumulating hash-word register, Q <= Q + data (mod 2^32).
// Latency: one cycle; Q reflects data sampled at edge n immediately after edge n.
// Backpressure: none; the word is added on every rising edge, data = 0 holds.
//
// Ports:
//   clk   : system clock, all state updates on its rising edge
//   reset : asynchronous, active-high; forces Q to INIT without waiting for clk
//   hif   : slave side of register_hash_32_if (data in, Q out)
//
// Parameter:
//   INIT  : reset value of Q; an H0..H7 instance may load its SHA-256 initial
//           hash constant here instead of zero.
module register_hash_32 #(
    parameter logic [31:0] INIT = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    register_hash_32_if.slave  hif
);

    logic [31:0] acc_q;
    logic [31:0] acc_sum;

    // Plain unsigned add; the carry out of bit 31 is dropped by the width,
    // which is exactly the modulo-2^32 wrap the hash update needs.
    assign acc_sum = acc_q + hif.data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= INIT;
        end else begin
            acc_q <= acc_sum;
        end
    end

    // Q comes straight from the flop: no combinational path from data to Q.
    assign hif.Q = acc_q;

endmodule

// File: tb/tb_register_hash_32.sv
// Purpose: self-checking bench for register_hash_32 with a scoreboard queue.
// Latency: expects Q updated one edge after each data word is presented.
// Backpressure: none; one word per clock edge.
module tb_register_hash_32;

    localparam logic [31:0] INIT = 32'h0000_0000;

    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic reset  = 1'b1;

    register_hash_32_if hif ();

    register_hash_32 #(.INIT(INIT)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif)
    );

    // Clock stays idle until enabled so the reset phase can run without edges.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    logic [31:0] sb[$];
    logic [31:0] model;
    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Pop the next expected value and compare it with Q.
    task automatic check_next(input string tag);
        logic [31:0] exp_v;
        if (sb.size() == 0) begin
            check_val({tag, "_sb_empty"}, hif.Q, 32'hxxxx_xxxx);
        end else begin
            exp_v = sb.pop_front();
            check_val(tag, hif.Q, exp_v);
        end
    endtask

    // Present one word, update the model, then check 1 ns after the edge.
    task automatic step(input logic [31:0] d, input string tag);
        hif.data = d;
        model    = model + d;
        sb.push_back(model);
        @(posedge clk);
        #1;
        check_next(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        hif.data = 32'h0;
        model    = INIT;

        // Reset held with idle clock.
        #100;
        sb.push_back(model);
        check_next("reset_value");

        // Release reset well before the first edge, then start the clock.
        reset  = 1'b0;
        clk_en = 1'b1;

        step(32'h666777aa, "load");
        check_val("load_const", hif.Q, 32'h666777aa);
        step(32'h666777aa, "accumulate");
        check_val("accumulate_const", hif.Q, 32'hCCCEEF54);

        // Async reset between edges, no clock edge involved.
        #2;
        reset = 1'b1;
        #1;
        model = INIT;
        sb.push_back(model);
        check_next("async_reset");

        // Clock keeps running with nonzero data while reset is held.
        hif.data = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            sb.push_back(model);
            check_next("reset_held");
        end

        // Release between edges; next edge accumulates from INIT.
        reset = 1'b0;
        step(32'h12345678, "post_reset_load");

        // Bring Q to 1, then wrap with all-ones.
        step(32'hEDCBA989, "reach_one");
        check_val("reach_one_const", hif.Q, 32'h00000001);
        step(32'hFFFFFFFF, "wrap");
        check_val("wrap_const", hif.Q, 32'h00000000);

        // Hold at a nonzero value for 5 edges.
        step(32'ha5a5a5a5, "pre_hold");
        for (int i = 0; i < 5; i++) begin
            step(32'h0, "hold");
        end

        // Random accumulation.
        for (int i = 0; i < 20; i++) begin
            r = $urandom;
            step(r, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
